// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO between the CPU datapath and data
// memory. Stores are accepted in one cycle and drained in order over a
// MemReq/MemAck handshake, with one idle cycle after every acknowledge.
//
// Optional feature: define STORE_FWD_EN to add store-to-load forwarding
// (LoadAddr / FwdHit / FwdData). The default build has no forwarding logic.
module store_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    StoreValid,
    output logic                    StoreReady,
    input  logic [ADDR_WIDTH-1:0]   StoreAddr,
    input  logic [DATA_WIDTH-1:0]   StoreData,
    output logic                    MemReq,
    output logic [ADDR_WIDTH-1:0]   MemAddr,
    output logic [DATA_WIDTH-1:0]   MemData,
    input  logic                    MemAck,
    output logic                    Empty,
    output logic [$clog2(DEPTH):0]  Count
`ifdef STORE_FWD_EN
    ,
    input  logic [ADDR_WIDTH-1:0]   LoadAddr,
    output logic                    FwdHit,
    output logic [DATA_WIDTH-1:0]   FwdData
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W:0]        count;

    logic                  push;
    logic                  pop;
    logic                  req_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] data_next;

    // Status flags come from registered occupancy only, so a full buffer
    // stays not-ready even in the cycle its head is acknowledged.
    assign StoreReady = (count != FULL_COUNT);
    assign Empty      = (count == '0);
    assign Count      = count;

    assign push = StoreValid && StoreReady;
    // The head leaves only when an outstanding request is acknowledged;
    // MemAck while idle has no effect.
    assign pop  = (state == ISSUE) && MemAck;

    // Drain FSM next-state and next request register values.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        state_next = state;
        req_next   = MemReq;
        addr_next  = MemAddr;
        data_next  = MemData;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    req_next   = 1'b1;
                    addr_next  = addr_mem[head];
                    data_next  = data_mem[head];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (MemAck) begin
                    req_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Drain FSM state and registered memory request outputs.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!Rst) begin
            state   <= IDLE;
            MemReq  <= 1'b0;
            MemAddr <= '0;
            MemData <= '0;
        end else begin
            state   <= state_next;
            MemReq  <= req_next;
            MemAddr <= addr_next;
            MemData <= data_next;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave Count alone.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage written at the tail on every accepted store.
    always_ff @(posedge Clk) begin
        // NOTE: the storage array has no reset; an entry is only ever read
        // after being written, and Count alone decides which entries are live.
        if (push) begin
            addr_mem[tail] <= StoreAddr;
            data_mem[tail] <= StoreData;
        end
    end

`ifdef STORE_FWD_EN
    // Scan live entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        FwdHit  = 1'b0;
        FwdData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (addr_mem[idx] == LoadAddr)) begin
                FwdHit  = 1'b1;
                FwdData = data_mem[idx];
            end
        end
    end
`endif

endmodule
